mips_mc_ctrl: RTL and testbench
===============================

Name: mips_mc_ctrl

Overview:
Multicycle MIPS control FSM that sequences the single-cycle-shared datapath: PC update, memory access, IR load, ALU operand/op selection, and register-file write-back. It drives the 2-bit register-destination select (rt / rd / $31) and the write-back source select. Memory accesses stall on a ready handshake, guarded by a watchdog counter. Sits between IR[31:26] and all datapath muxes and enables.

Parameters:
WAIT_MAX, 15, max stall cycles in any memory state before trapping (1..255)
WCNT_W, 8, width of the stall counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
opcode  input  6  IR[31:26], valid from DECODE onward
zero  input  1  ALU zero flag (informational; branch gating is external via PCWriteCond)
mem_ready  input  1  memory completes the current access this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if zero
iord  output  1  0=PC, 1=ALUOut as memory address
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
ir_write  output  1  IR load
reg_write  output  1  register file write enable
reg_dst  output  2  00=rt, 01=rd, 10=$31, 11=unused (never driven)
mem_to_reg  output  2  00=ALUOut, 01=MDR, 10=PC
alu_src_a  output  1  0=PC, 1=A
alu_src_b  output  2  00=B, 01=4, 10=sign-ext imm, 11=imm<<2
alu_op  output  2  00=add, 01=sub, 10=funct
pc_source  output  2  00=ALU, 01=ALUOut, 10=jump target
illegal_op  output  1  high in TRAP for illegal opcode
mem_timeout  output  1  high in TRAP for stall timeout
state_o  output  4  current state encoding (debug)

Behaviour:
- Reset: rst_n low -> state=FETCH (0), stall counter=0; all control outputs forced 0 while rst_n low, state_o=0. First active FETCH cycle is the first clk edge after release.
- States (encoding): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, WB_LOAD 4, MEM_WRITE 5, EXEC_R 6, WB_R 7, BRANCH 8, JUMP 9, JAL 10, EXEC_I 11, WB_I 12, TRAP 13. 14/15 -> FETCH next cycle, outputs 0.
- Outputs are Moore decode of state; unlisted outputs 0 in that state. Exceptions: ir_write and pc_write in FETCH are mem_ready-gated (Mealy).
- FETCH: mem_read=1, iord=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready. Stay until mem_ready -> DECODE.
- DECODE: alu_src_b=11, alu_op=00. Next by opcode: 000000 EXEC_R; 100011/101011 MEM_ADDR; 000100 BRANCH; 000010 JUMP; 000011 JAL; 001000 EXEC_I; other TRAP (illegal).
- MEM_ADDR: alu_src_a=1, alu_src_b=10 -> MEM_READ if lw, MEM_WRITE if sw (opcode sampled again; must be stable).
- MEM_READ: mem_read=1, iord=1; wait mem_ready -> WB_LOAD.
- WB_LOAD: reg_write=1, reg_dst=00, mem_to_reg=01 -> FETCH.
- MEM_WRITE: mem_write=1, iord=1; wait mem_ready -> FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> WB_R. WB_R: reg_write=1, reg_dst=01 -> FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
- JUMP: pc_write=1, pc_source=10 -> FETCH.
- JAL: reg_write=1, reg_dst=10, mem_to_reg=10, pc_write=1, pc_source=10 -> FETCH (PC+4 already in PC).
- EXEC_I: alu_src_a=1, alu_src_b=10 -> WB_I. WB_I: reg_write=1, reg_dst=00 -> FETCH.
- Stall counter: counts cycles in FETCH/MEM_READ/MEM_WRITE with mem_ready=0; clears on any state change or mem_ready=1. Reaching WAIT_MAX with mem_ready still 0 -> TRAP with timeout cause; mem_ready=1 on that same cycle wins (normal advance).
- TRAP: one cycle; illegal_op or mem_timeout =1 per latched cause; no writes; -> FETCH; cause cleared on exit.
- Reset mid-operation: strobes drop asynchronously the instant rst_n falls; no partial write-back.

Test Plan:
- R-type (opcode 000000), mem_ready=1 -> states 0,1,6,7,0; WB_R shows reg_write=1, reg_dst=01; 4 cycles/instr.
- lw (100011), mem_ready low 2 cycles in MEM_READ -> MEM_READ held 3 cycles, mem_read=1 iord=1 throughout; WB_LOAD reg_dst=00 mem_to_reg=01.
- jal (000011) -> 0,1,10,0; in JAL reg_dst=10, mem_to_reg=10, pc_write=1, pc_source=10.
- Illegal opcode 111111 -> DECODE -> TRAP with illegal_op=1 one cycle, mem_timeout=0, reg_write/mem_write 0, then FETCH.
- FETCH with mem_ready held 0, WAIT_MAX=15 -> TRAP after 15 stall cycles, mem_timeout=1; repeat with mem_ready=1 on cycle 15 -> DECODE, no trap.
- sw in MEM_WRITE, rst_n pulled low mid-cycle -> mem_write=0 immediately, state_o=0; after release FETCH with mem_read=1.

Source files
------------

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: sequences PC, memory, IR, ALU and write-back.
// Memory states stall on mem_ready under a watchdog that traps on timeout.
module mips_mc_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int WCNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MADDR   = 4'd2,
    S_MREAD   = 4'd3,
    S_WBLOAD  = 4'd4,
    S_MWRITE  = 4'd5,
    S_EXECR   = 4'd6,
    S_WBR     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_JAL     = 4'd10,
    S_EXECI   = 4'd11,
    S_WBI     = 4'd12,
    S_TRAP    = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(WAIT_MAX - 1);

  state_t            state;
  state_t            nxt;
  logic [WCNT_W-1:0] wcnt;
  logic              c_ill;
  logic              c_to;
  logic              mem_st;
  logic              stall;
  logic              tmo;

  assign mem_st = (state == S_FETCH) || (state == S_MREAD) ||
                  (state == S_MWRITE);
  assign stall  = mem_st && !mem_ready;
  assign tmo    = stall && (wcnt == WLAST);
  assign state_o = state;

  always_comb begin
    nxt = S_FETCH;
    unique case (state)
      S_FETCH:  nxt = mem_ready ? S_DECODE : (tmo ? S_TRAP : S_FETCH);
      S_DECODE: begin
        unique case (1'b1)
          opcode == OP_R:    nxt = S_EXECR;
          opcode == OP_LW,
          opcode == OP_SW:   nxt = S_MADDR;
          opcode == OP_BEQ:  nxt = S_BRANCH;
          opcode == OP_J:    nxt = S_JUMP;
          opcode == OP_JAL:  nxt = S_JAL;
          opcode == OP_ADDI: nxt = S_EXECI;
          default:           nxt = S_TRAP;
        endcase
      end
      // opcode re-sampled; a non-memory op here is treated as illegal
      S_MADDR:  nxt = (opcode == OP_LW) ? S_MREAD :
                      (opcode == OP_SW) ? S_MWRITE : S_TRAP;
      S_MREAD:  nxt = mem_ready ? S_WBLOAD : (tmo ? S_TRAP : S_MREAD);
      S_MWRITE: nxt = mem_ready ? S_FETCH : (tmo ? S_TRAP : S_MWRITE);
      S_EXECR:  nxt = S_WBR;
      S_EXECI:  nxt = S_WBI;
      default:  nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      wcnt  <= '0;
      c_ill <= 1'b0;
      c_to  <= 1'b0;
    end else begin
      state <= nxt;
      wcnt  <= (stall && nxt == state) ? wcnt + 1'b1 : '0;
      c_ill <= (nxt == S_TRAP) && !tmo;
      c_to  <= (nxt == S_TRAP) && tmo;
    end
  end

  // Decode is gated by rst_n so strobes drop the instant reset asserts
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    mem_timeout   = 1'b0;
    if (rst_n) begin
      unique case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: alu_src_b = 2'b11;
        S_MADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MREAD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_WBLOAD: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'b01;
        end
        S_MWRITE: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_EXECR: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_WBR: begin
          reg_write = 1'b1;
          reg_dst   = 2'b01;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        S_JAL: begin
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
          pc_write   = 1'b1;
          pc_source  = 2'b10;
        end
        S_EXECI: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_WBI: reg_write = 1'b1;
        S_TRAP: begin
          illegal_op  = c_ill;
          mem_timeout = c_to;
        end
        default: ;
      endcase
    end
  end

  logic unused_zero;
  assign unused_zero = zero;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Randomized bench: each instruction expands into an expected per-cycle
// trace (state + control word) from the instruction's timing rules.
module tb_mips_mc_ctrl;

  localparam int W = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write;
  logic       ir_write, reg_write, alu_src_a, illegal_op, mem_timeout;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
  logic [3:0] state_o;

  mips_mc_ctrl #(.WAIT_MAX(W), .WCNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    bit rdy;
    bit ill;
    bit to;
  } rec_t;

  rec_t q[$];
  int   nchk = 0;
  int   nerr = 0;

  wire [19:0] obs = {pc_write, pc_write_cond, iord, mem_read, mem_write,
                     ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
                     alu_src_b, alu_op, pc_source, illegal_op, mem_timeout};

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] exp_ctl(rec_t r);
    logic pw, pwc, io, mr, mw, irw, rw, asa;
    logic [1:0] rd, m2r, asb, aop, ps;
    {pw, pwc, io, mr, mw, irw, rw, asa} = '0;
    {rd, m2r, asb, aop, ps} = '0;
    case (r.st)
      0:  begin mr = 1; asb = 2'b01; irw = r.rdy; pw = r.rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; m2r = 2'b01; end
      5:  begin mw = 1; io = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 2'b01; end
      8:  begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
      9:  begin pw = 1; ps = 2'b10; end
      10: begin rw = 1; rd = 2'b10; m2r = 2'b10; pw = 1; ps = 2'b10; end
      11: begin asa = 1; asb = 2'b10; end
      12: rw = 1;
      default: ;
    endcase
    return {pw, pwc, io, mr, mw, irw, rw, rd, m2r, asa, asb, aop, ps,
            r.ill && r.st == 13, r.to && r.st == 13};
  endfunction

  function automatic rec_t mk(int st, bit rdy, bit ill, bit to);
    rec_t r;
    r.st = st; r.rdy = rdy; r.ill = ill; r.to = to;
    return r;
  endfunction

  // k stall cycles then ready; k >= W means the watchdog fires
  task automatic push_mem(int st, int k, output bit ab);
    ab = 0;
    for (int i = 0; i < k && i < W; i++) q.push_back(mk(st, 0, 0, 0));
    if (k >= W) begin
      q.push_back(mk(13, 1'($urandom), 0, 1));
      ab = 1;
    end else q.push_back(mk(st, 1, 0, 0));
  endtask

  task automatic gen(logic [5:0] op, int kf, int km);
    bit ab;
    push_mem(0, kf, ab);
    if (ab) return;
    q.push_back(mk(1, 1'($urandom), 0, 0));
    case (op)
      6'b000000: begin
        q.push_back(mk(6, 1'($urandom), 0, 0));
        q.push_back(mk(7, 1'($urandom), 0, 0));
      end
      6'b100011: begin
        q.push_back(mk(2, 1'($urandom), 0, 0));
        push_mem(3, km, ab);
        if (!ab) q.push_back(mk(4, 1'($urandom), 0, 0));
      end
      6'b101011: begin
        q.push_back(mk(2, 1'($urandom), 0, 0));
        push_mem(5, km, ab);
      end
      6'b000100: q.push_back(mk(8, 1'($urandom), 0, 0));
      6'b000010: q.push_back(mk(9, 1'($urandom), 0, 0));
      6'b000011: q.push_back(mk(10, 1'($urandom), 0, 0));
      6'b001000: begin
        q.push_back(mk(11, 1'($urandom), 0, 0));
        q.push_back(mk(12, 1'($urandom), 0, 0));
      end
      default: q.push_back(mk(13, 1'($urandom), 1, 0));
    endcase
  endtask

  // Called at a negedge; leaves the bench at the next negedge
  task automatic step();
    rec_t r;
    r = q.pop_front();
    mem_ready = r.rdy;
    zero = 1'($urandom);
    #1;
    check("state", 32'(state_o), 32'(r.st));
    check("ctl", 32'(obs), 32'(exp_ctl(r)));
    @(negedge clk);
  endtask

  task automatic run_instr(logic [5:0] op, int kf, int km);
    opcode = op;
    gen(op, kf, km);
    while (q.size() > 0) step();
  endtask

  function automatic int rnd_stall();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(10, 20));
    return int'($urandom_range(0, 3));
  endfunction

  logic [5:0] ops [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                          6'b000010, 6'b000011, 6'b001000};

  initial begin
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_ctl", 32'(obs), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_instr(6'b000000, 0, 0);
    run_instr(6'b100011, 0, 2);
    run_instr(6'b000011, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(6'b000000, W + 3, 0);
    run_instr(6'b000000, W - 1, 0);
    run_instr(6'b101011, 1, W);
    run_instr(6'b100011, 0, W - 1);

    // Reset pulled mid-MEM_WRITE
    opcode = 6'b101011;
    gen(6'b101011, 0, 40);
    while (q.size() > 0 && q[0].st != 5) step();
    mem_ready = 1'b0;
    #1;
    check("mw_pre", 32'(mem_write), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mw_rst", 32'(mem_write), 32'd0);
    check("st_rst", 32'(state_o), 32'd0);
    check("mr_rst", 32'(mem_read), 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(6'b000000, 0, 0);

    for (int n = 0; n < 300; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom)
                                       : ops[$urandom_range(0, 6)];
      run_instr(op, rnd_stall(), rnd_stall());
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
